// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared types, register addresses and helpers for the LED controller
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_PWM    = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_VALUE  = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// rtl/led_ctrl_if.sv - register bus between the decoder and the LED controller
interface led_ctrl_if;
    logic        en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] rd_data;

    modport master (output en, output wr_en, output addr, output data, input rd_data);
    modport slave  (input en, input wr_en, input addr, input data, output rd_data);
endinterface

// File: rtl/led_ctrl_defs.vh
// rtl/led_ctrl_defs.vh - register map, mode encodings and field positions for software and the bus decoder
`ifndef LED_CTRL_DEFS_VH
`define LED_CTRL_DEFS_VH

`define LED_CTRL_ADDR_CTRL       2'd0
`define LED_CTRL_ADDR_VALUE      2'd1
`define LED_CTRL_ADDR_DUTY       2'd2
`define LED_CTRL_ADDR_STATUS     2'd3

`define LED_CTRL_MODE_DIRECT     2'd0
`define LED_CTRL_MODE_BLINK      2'd1
`define LED_CTRL_MODE_ROTATE     2'd2
`define LED_CTRL_MODE_PWM        2'd3

`define LED_CTRL_CTRL_MODE_LSB   0
`define LED_CTRL_CTRL_MODE_MSB   1
`define LED_CTRL_CTRL_PERIOD_LSB 8
`define LED_CTRL_CTRL_PERIOD_MSB 15
`define LED_CTRL_VALUE_LSB       0
`define LED_CTRL_VALUE_MSB       7
`define LED_CTRL_DUTY_LSB        0
`define LED_CTRL_DUTY_MSB        7
`define LED_CTRL_STATUS_LED_LSB  0
`define LED_CTRL_STATUS_LED_MSB  7
`define LED_CTRL_STATUS_STEP_BIT 8

`endif

// File: rtl/led_tick.sv
// rtl/led_tick.sv - free-running prescaler emitting a registered one-cycle tick every PRESCALE clocks
module led_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;
    logic        r_tick;

    // Registered tick: first pulse is consumed PRESCALE edges after the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - register-programmed 8-LED driver with direct, blink, rotate and PWM modes
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    led_ctrl_if.slave      bus,
    output logic [7:0]     led_out
);
    logic        w_tick;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_value;
    logic        w_wr_duty;
    logic        w_step;
    logic        w_step_apply;
    mode_e       w_new_mode;
    logic [7:0]  w_led_next;
    logic [15:0] w_rd_mux;

    mode_e       r_mode;
    logic [7:0]  r_period;
    logic [7:0]  r_value;
    logic [7:0]  r_duty;
    logic [7:0]  r_work;
    logic [7:0]  r_step_cnt;
    logic        r_phase;
    logic [7:0]  r_pwm_cnt;
    logic        r_step_d;
    logic [7:0]  r_led;
    logic [15:0] r_rd_data;

    led_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_wr         = bus.en & bus.wr_en;
    assign w_rd         = bus.en & ~bus.wr_en;
    assign w_wr_ctrl    = w_wr && (bus.addr == ADDR_CTRL);
    assign w_wr_value   = w_wr && (bus.addr == ADDR_VALUE);
    assign w_wr_duty    = w_wr && (bus.addr == ADDR_DUTY);
    assign w_new_mode   = mode_e'(bus.data[1:0]);
    assign w_step       = w_tick && (r_step_cnt == r_period);
    // A register write in the same cycle as a step wins; the step's effect is dropped.
    assign w_step_apply = w_step && !w_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_DIRECT;
            r_period <= '0;
            r_value  <= '0;
            r_duty   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_mode   <= w_new_mode;
                r_period <= bus.data[15:8];
            end
            if (w_wr_value) r_value <= bus.data[7:0];
            if (w_wr_duty)  r_duty  <= bus.data[7:0];
        end
    end

    // CTRL writes restart the pattern timebase; the prescaler keeps running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_phase    <= 1'b0;
            r_pwm_cnt  <= '0;
            r_step_d   <= 1'b0;
        end else begin
            r_step_d <= w_step;
            if (w_wr_ctrl) begin
                r_step_cnt <= '0;
                r_phase    <= 1'b0;
                r_pwm_cnt  <= '0;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                if (w_tick) r_step_cnt <= w_step ? 8'd0 : r_step_cnt + 8'd1;
                if (w_step_apply) r_phase <= ~r_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
        end else if (w_wr_ctrl && (w_new_mode == MODE_ROTATE) && (r_mode != MODE_ROTATE)) begin
            r_work <= r_value;
        end else if (w_wr_value && (r_mode == MODE_ROTATE)) begin
            r_work <= bus.data[7:0];
        end else if (w_step_apply && (r_mode == MODE_ROTATE)) begin
            r_work <= rotl8(r_work);
        end
    end

    always_comb begin
        w_led_next = 8'h00;
        case (r_mode)
            MODE_DIRECT: w_led_next = r_value;
            MODE_BLINK:  w_led_next = r_phase ? r_value : 8'h00;
            MODE_ROTATE: w_led_next = r_work;
            MODE_PWM:    w_led_next = (r_pwm_cnt < r_duty) ? r_value : 8'h00;
            default:     w_led_next = 8'h00;
        endcase
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (bus.addr)
            ADDR_CTRL:   w_rd_mux = {r_period, 6'b0, r_mode};
            ADDR_VALUE:  w_rd_mux = {8'h00, r_value};
            ADDR_DUTY:   w_rd_mux = {8'h00, r_duty};
            ADDR_STATUS: w_rd_mux = {7'b0, r_step_d, r_led};
            default:     w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= '0;
            r_rd_data <= '0;
        end else begin
            r_led <= w_led_next;
            if (w_rd) r_rd_data <= w_rd_mux;
        end
    end

    assign led_out     = r_led;
    assign bus.rd_data = r_rd_data;
endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - directed self-checking bench for led_ctrl with PRESCALE=4
module tb_led_ctrl;
    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_out;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    led_ctrl_if u_if ();

    led_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (u_if.slave),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: edge 1 is the first rising edge with rst_n=1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        u_if.en    = 1'b0;
        u_if.wr_en = 1'b0;
        u_if.addr  = 2'd0;
        u_if.data  = 16'h0000;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        u_if.en    = 1'b1;
        u_if.wr_en = 1'b1;
        u_if.addr  = a;
        u_if.data  = d;
        step_clk();
        bus_idle();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        u_if.en    = 1'b1;
        u_if.wr_en = 1'b0;
        u_if.addr  = a;
        step_clk();
        bus_idle();
        d = u_if.rd_data;
    endtask

    // Ticks are consumed on edges 5, 9, 13, ...; with period 0 a STATUS read on edge m sees the step of edge m-1.
    function automatic logic step_seen(input int m);
        return (m >= 6) && (m % 4 == 2);
    endfunction

    task automatic measure_run(output logic [7:0] v, output int len);
        v   = led_out;
        len = 0;
        while (led_out === v && len < 40) begin
            step_clk();
            len++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b0;
        bus_idle();
        repeat (3) step_clk();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led_out); end
        checks++;
        if (u_if.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd: got %h expected 0000", u_if.rd_data); end
        u_if.en = 1'b1; u_if.wr_en = 1'b1; u_if.addr = 2'd1; u_if.data = 16'hFFFF;
        step_clk();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL reset_write_ignored: got %h expected 00", led_out); end
        u_if.wr_en = 1'b0; u_if.addr = 2'd3;
        rst_n = 1'b1;
        d = 16'h0;
    endtask

    task automatic test_first_tick();
        logic [15:0] exp;
        for (int m = 1; m <= 12; m++) begin
            step_clk();
            exp = {7'b0, step_seen(m), 8'h00};
            checks++;
            if (u_if.rd_data !== exp)
                begin errors++; $display("FAIL first_tick edge %0d: got %h expected %h", m, u_if.rd_data, exp); end
        end
        bus_idle();
    endtask

    task automatic test_direct();
        logic [15:0] d;
        logic [15:0] exp;
        write_reg(2'd1, 16'h00A5);
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL direct_latency: got %h expected 00", led_out); end
        step_clk();
        checks++;
        if (led_out !== 8'hA5) begin errors++; $display("FAIL direct_led: got %h expected a5", led_out); end
        read_reg(2'd3, d);
        exp = {7'b0, step_seen(cyc), 8'hA5};
        checks++;
        if (d !== exp) begin errors++; $display("FAIL direct_status: got %h expected %h", d, exp); end
        repeat (3) step_clk();
        checks++;
        if (u_if.rd_data !== exp) begin errors++; $display("FAIL rd_hold: got %h expected %h", u_if.rd_data, exp); end
        write_reg(2'd0, 16'h00FC);
        read_reg(2'd0, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_unused_bits: got %h expected 0000", d); end
        write_reg(2'd1, 16'h12A5);
        read_reg(2'd1, d);
        checks++;
        if (d !== 16'h00A5) begin errors++; $display("FAIL value_readback: got %h expected 00a5", d); end
        write_reg(2'd3, 16'hFFFF);
        step_clk();
        checks++;
        if (led_out !== 8'hA5) begin errors++; $display("FAIL status_write_ignored: got %h expected a5", led_out); end
        write_reg(2'd2, 16'hBE77);
        read_reg(2'd2, d);
        checks++;
        if (d !== 16'h0077) begin errors++; $display("FAIL duty_readback: got %h expected 0077", d); end
    endtask

    task automatic test_blink();
        logic [7:0] v;
        int         len;
        logic [7:0] exp_v;
        write_reg(2'd1, 16'h00FF);
        write_reg(2'd0, 16'h0101);
        step_clk();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL blink_entry: got %h expected 00", led_out); end
        measure_run(v, len);
        checks++;
        if (len >= 40) begin errors++; $display("FAIL blink_first_step: got run %0d expected < 40", len); end
        exp_v = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            measure_run(v, len);
            checks++;
            if (v !== exp_v || len != 8)
                begin errors++; $display("FAIL blink_run %0d: got %h for %0d cycles expected %h for 8", k, v, len, exp_v); end
            exp_v = ~exp_v;
        end
    endtask

    task automatic test_rotate();
        logic [7:0] seq [8];
        logic [7:0] v;
        int         len;
        seq = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        write_reg(2'd1, 16'h0081);
        write_reg(2'd0, 16'h0002);
        step_clk();
        checks++;
        if (led_out !== 8'h81) begin errors++; $display("FAIL rotate_entry: got %h expected 81", led_out); end
        measure_run(v, len);
        checks++;
        if (len >= 40) begin errors++; $display("FAIL rotate_first_step: got run %0d expected < 40", len); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (led_out !== seq[i]) begin errors++; $display("FAIL rotate_seq %0d: got %h expected %h", i, led_out, seq[i]); end
            if (i < 7) begin
                measure_run(v, len);
                checks++;
                if (len != 4) begin errors++; $display("FAIL rotate_interval %0d: got %0d expected 4", i, len); end
            end
        end
    endtask

    task automatic test_write_on_step();
        logic [15:0] d;
        while (cyc % 4 != 0) step_clk();
        write_reg(2'd1, 16'h005A);
        step_clk();
        checks++;
        if (led_out !== 8'h5A) begin errors++; $display("FAIL wos_led: got %h expected 5a", led_out); end
        read_reg(2'd3, d);
        checks++;
        if (d !== 16'h005A) begin errors++; $display("FAIL wos_status: got %h expected 005a", d); end
        step_clk();
        step_clk();
        checks++;
        if (led_out !== 8'h5A) begin errors++; $display("FAIL wos_hold: got %h expected 5a", led_out); end
        step_clk();
        checks++;
        if (led_out !== 8'hB4) begin errors++; $display("FAIL wos_next_step: got %h expected b4", led_out); end
    endtask

    task automatic test_pwm();
        int on;
        int bad;
        logic [7:0] exp;
        write_reg(2'd1, 16'h000F);
        write_reg(2'd2, 16'h0040);
        write_reg(2'd0, 16'h0003);
        on = 0; bad = 0;
        for (int k = 1; k <= 256; k++) begin
            step_clk();
            exp = ((k - 1) < 64) ? 8'h0F : 8'h00;
            if (led_out !== exp) bad++;
            if (led_out === 8'h0F) on++;
        end
        checks++;
        if (on != 64) begin errors++; $display("FAIL pwm_on_64: got %0d expected 64", on); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pwm_phase: got %0d wrong cycles expected 0", bad); end
        write_reg(2'd2, 16'h0000);
        on = 0;
        for (int k = 0; k < 256; k++) begin
            step_clk();
            if (led_out !== 8'h00) on++;
        end
        checks++;
        if (on != 0) begin errors++; $display("FAIL pwm_duty0: got %0d on cycles expected 0", on); end
        write_reg(2'd2, 16'h00FF);
        on = 0;
        for (int k = 0; k < 256; k++) begin
            step_clk();
            if (led_out === 8'h0F) on++;
        end
        checks++;
        if (on != 255) begin errors++; $display("FAIL pwm_duty255: got %0d on cycles expected 255", on); end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        int n;
        write_reg(2'd1, 16'h00FF);
        write_reg(2'd0, 16'h0101);
        n = 0;
        while (led_out !== 8'hFF && n < 20) begin
            step_clk();
            n++;
        end
        checks++;
        if (led_out !== 8'hFF) begin errors++; $display("FAIL arst_blink_on: got %h expected ff", led_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL arst_async_zero: got %h expected 00", led_out); end
        step_clk();
        step_clk();
        rst_n = 1'b1;
        read_reg(2'd0, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL arst_ctrl: got %h expected 0000", d); end
        read_reg(2'd1, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL arst_value: got %h expected 0000", d); end
        step_clk();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL arst_led_after: got %h expected 00", led_out); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_first_tick();
        test_direct();
        test_blink();
        test_rotate();
        test_write_on_step();
        test_pwm();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per step tick (legal 2..65535).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1. Reset is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1, peripheral select from the bus decoder.
REQ-005 SHALL have port wr_en, input, 1, write strobe, qualified by en.
REQ-006 SHALL have port addr, input, 2, register select.
REQ-007 SHALL have port data, input, 16, write data.
REQ-008 SHALL have port rd_data, output, 16, registered read data.
REQ-009 SHALL have port led_out, output, 8, LED drive.

Function
REQ-010 Register map SHALL be:
- 0 CTRL (RW): [1:0] mode; [15:8] period; [7:2] read 0.
- 1 VALUE (RW): [7:0] pattern.
- 2 DUTY (RW): [7:0].
- 3 STATUS (RO): [7:0] led_out; [8] step pulse of last cycle.
REQ-011 Modes SHALL be 0 DIRECT, 1 BLINK, 2 ROTATE, 3 PWM.
REQ-012 Write SHALL occur on the clk edge where en=1 and wr_en=1; writes to addr 3 are ignored.
REQ-013 Read SHALL occur when en=1 and wr_en=0; rd_data is valid the next cycle and holds until the next read; unused bits read 0.
REQ-014 Tick generator SHALL pulse tick for 1 cycle every PRESCALE cycles, free-running from reset.
REQ-015 Step counter (8 bit) SHALL increment on tick; step pulse fires on the tick where count == period, then count returns to 0; period=0 gives a step every tick.
REQ-016 DIRECT: led_out = VALUE, registered, 1-cycle latency from the VALUE write.
REQ-017 BLINK: phase bit toggles each step; led_out = VALUE when phase=1, else 0.
REQ-018 ROTATE: working register loads VALUE on entry to the mode and on each VALUE write, then rotates left by 1 per step (bit7 -> bit0); led_out = working register.
REQ-019 PWM: 8-bit pwm_cnt increments every clk and wraps 255 -> 0; led_out = VALUE when pwm_cnt < DUTY, else 0. DUTY=0 is always off; DUTY=255 is on 255 of 256 cycles.
REQ-020 A CTRL write SHALL clear the step counter, phase and pwm_cnt in the same edge. The prescaler is not cleared.
REQ-021 Write and step in the same cycle SHALL apply the write, and that step is discarded.
REQ-022 Mode and period changes SHALL take effect on led_out within 2 cycles.

Reset
REQ-023 While rst_n=0, all registers SHALL be 0: CTRL, VALUE, DUTY, working register, counters, phase, rd_data and led_out.
REQ-024 Reset assertion mid-operation SHALL zero led_out asynchronously.
REQ-025 After release, the first tick SHALL occur PRESCALE cycles after the first clk edge with rst_n=1.

Structure
REQ-026 Mode encodings, register addresses and field positions SHALL live in a shared header, led_ctrl_defs.vh, for use by software tests and the bus decoder.
REQ-027 The tick generator SHALL be a sub-module, led_tick (params PRESCALE; ports clk, rst_n, tick).
REQ-028 Target size is 120-400 lines of RTL, fully synchronous except for reset.

Verification (PRESCALE=4)
REQ-029 Reset, then write VALUE=0x00A5 in DIRECT -> led_out=0xA5 one cycle later; read addr 3 -> rd_data=0x00A5 the next cycle.
REQ-030 CTRL=0x0101 (BLINK, period 1), VALUE=0xFF -> led_out alternates 0xFF/0x00, each held 8 cycles.
REQ-031 VALUE=0x81, then CTRL=0x0002 (ROTATE, period 0) -> led_out goes 0x81, 0x03, 0x06 ... with a step every 4 cycles, and 0x81 recurs after 8 steps.
REQ-032 CTRL=3, VALUE=0x0F, DUTY=0x40 -> led_out=0x0F for exactly 64 of every 256 cycles; DUTY=0 gives constant 0.
REQ-033 VALUE write coinciding with a step in ROTATE -> led_out shows the written value, not rotated; reads of addr 3 return it.
REQ-034 rst_n low mid-BLINK with led_out=0xFF -> led_out=0 without a clk edge; after release, DIRECT mode with VALUE=0.
